// File: rtl/rf_bank_req_queue.sv
// -----------------------------------------------------------------------------
// rf_bank_req_queue
//
// Purpose:
//   Request queue between the operand-collector dispatch stage and the four
//   register-file banks. Each dispatched instruction carries up to two operand
//   reads (A and B). Every valid operand becomes a {row, ocid} entry that is
//   pushed into the FIFO of the bank it lives in. Each bank then issues at most
//   one access per cycle. A CDB write-back to a bank takes that bank's slot,
//   and any pending read waits. Every issued read carries the OC id, so the
//   matching collector unit can capture the bank data.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_en                   dispatch request strobe
//   op_a_vld / op_b_vld      operand A / B present in the request
//   rowid_a, bankid_a        row / bank of operand A
//   rowid_b, bankid_b        row / bank of operand B
//   ocid                     destination collector unit
//   req_ready                registered: every FIFO has room for two pushes
//   wb_en, wb_bank, wb_row   CDB register write-back
//   bk_rd_vld[n]             read issued to bank n (one-cycle pulse)
//   bk_rd_row                bank n row in bits [3n+2:3n] (held when idle)
//   bk_rd_ocid               bank n OC tag in bits [2n+1:2n] (held when idle)
//   bk_wr_en[n]              write issued to bank n (one-cycle pulse)
//   bk_wr_row                write row
//   bk_bz[n]                 write took bank n's slot while a read was queued
// -----------------------------------------------------------------------------
module rf_bank_req_queue #(
    parameter int NBANK = 4,
    parameter int DEPTH = 4,
    parameter int ROWW  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_en,
    input  logic                   op_a_vld,
    input  logic                   op_b_vld,
    input  logic [ROWW-1:0]        rowid_a,
    input  logic [1:0]             bankid_a,
    input  logic [ROWW-1:0]        rowid_b,
    input  logic [1:0]             bankid_b,
    input  logic [1:0]             ocid,
    output logic                   req_ready,
    input  logic                   wb_en,
    input  logic [1:0]             wb_bank,
    input  logic [ROWW-1:0]        wb_row,
    output logic [NBANK-1:0]       bk_rd_vld,
    output logic [NBANK*ROWW-1:0]  bk_rd_row,
    output logic [NBANK*2-1:0]     bk_rd_ocid,
    output logic [NBANK-1:0]       bk_wr_en,
    output logic [ROWW-1:0]        bk_wr_row,
    output logic [NBANK-1:0]       bk_bz
);

    localparam int BIDW = 2;
    localparam int OCW  = 2;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = ROWW + OCW;

    // A FIFO at or below this count can absorb the two pushes of one request.
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic              req_ready_q;
    logic              req_ready_d;
    logic              accept;
    logic [NBANK-1:0]  fits_d;
    logic [EW-1:0]     entry_a;
    logic [EW-1:0]     entry_b;

    logic [NBANK-1:0]  wr_en_q;
    logic [NBANK-1:0]  wr_en_d;
    logic [ROWW-1:0]   wr_row_q;
    logic [ROWW-1:0]   wr_row_d;

    // req_ready is a flop, so accepting a request depends only on registered
    // state. It does not depend on this cycle's pops or write-backs.
    assign accept  = req_en && req_ready_q;
    assign entry_a = {rowid_a, ocid};
    assign entry_b = {rowid_b, ocid};

    // -------------------------------------------------------------------------
    // Per-bank FIFO and issue slot
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [EW-1:0]   mem_q [DEPTH];
            logic [PW-1:0]   rd_ptr_q;
            logic [PW-1:0]   rd_ptr_d;
            logic [PW-1:0]   wr_ptr_q;
            logic [PW-1:0]   wr_ptr_d;
            logic [CW-1:0]   count_q;
            logic [CW-1:0]   count_d;

            logic            push_a;
            logic            push_b;
            logic            wr_hit;
            logic            pop;
            logic [EW-1:0]   head;

            // Up to two writes per cycle. Port 0 takes the first push and
            // port 1 takes the second, so A lands ahead of B when they share
            // a bank.
            logic            we0;
            logic            we1;
            logic [PW-1:0]   wa0;
            logic [PW-1:0]   wa1;
            logic [EW-1:0]   wd0;

            logic            rd_vld_q;
            logic            rd_vld_d;
            logic [ROWW-1:0] rd_row_q;
            logic [ROWW-1:0] rd_row_d;
            logic [OCW-1:0]  rd_ocid_q;
            logic [OCW-1:0]  rd_ocid_d;
            logic            bz_q;
            logic            bz_d;

            assign head = mem_q[rd_ptr_q];

            always_comb begin
                push_a = accept && op_a_vld && (bankid_a == BIDW'(gi));
                push_b = accept && op_b_vld && (bankid_b == BIDW'(gi));
                wr_hit = wb_en && (wb_bank == BIDW'(gi));
                // A write-back owns the slot. The head entry stays queued.
                pop    = !wr_hit && (count_q != '0);

                we0 = push_a || push_b;
                we1 = push_a && push_b;
                wa0 = wr_ptr_q;
                wa1 = wr_ptr_q + PW'(1);
                wd0 = push_a ? entry_a : entry_b;

                wr_ptr_d = wr_ptr_q + PW'(push_a) + PW'(push_b);
                rd_ptr_d = rd_ptr_q + PW'(pop);
                count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);

                rd_vld_d  = pop;
                rd_row_d  = rd_row_q;
                rd_ocid_d = rd_ocid_q;
                if (pop) begin
                    rd_row_d  = head[EW-1:OCW];
                    rd_ocid_d = head[OCW-1:0];
                end
                bz_d = wr_hit && (count_q != '0);
            end

            assign fits_d[gi] = (count_d <= READY_MAX);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_ptr_q  <= '0;
                    wr_ptr_q  <= '0;
                    count_q   <= '0;
                    rd_vld_q  <= 1'b0;
                    rd_row_q  <= '0;
                    rd_ocid_q <= '0;
                    bz_q      <= 1'b0;
                end else begin
                    rd_ptr_q  <= rd_ptr_d;
                    wr_ptr_q  <= wr_ptr_d;
                    count_q   <= count_d;
                    rd_vld_q  <= rd_vld_d;
                    rd_row_q  <= rd_row_d;
                    rd_ocid_q <= rd_ocid_d;
                    bz_q      <= bz_d;
                end
            end

            // Entry storage needs no reset. Only slots between the read and
            // write pointers are ever observed, and reset collapses that range.
            always_ff @(posedge clk) begin
                if (we0) begin
                    mem_q[wa0] <= wd0;
                end
                if (we1) begin
                    mem_q[wa1] <= entry_b;
                end
            end

            assign bk_rd_vld[gi]                 = rd_vld_q;
            assign bk_rd_row[gi*ROWW +: ROWW]    = rd_row_q;
            assign bk_rd_ocid[gi*OCW +: OCW]     = rd_ocid_q;
            assign bk_bz[gi]                     = bz_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Write-back issue and request-ready flag
    // -------------------------------------------------------------------------
    always_comb begin
        wr_en_d  = '0;
        wr_row_d = wr_row_q;
        if (wb_en) begin
            wr_en_d  = NBANK'(1) << wb_bank;
            wr_row_d = wb_row;
        end
        // Ready is computed from next-state counts, so it is correct in the
        // same cycle the counts it describes become visible.
        req_ready_d = &fits_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q     <= '0;
            wr_row_q    <= '0;
            req_ready_q <= 1'b1;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_row_q    <= wr_row_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bk_wr_en  = wr_en_q;
    assign bk_wr_row = wr_row_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_rf_bank_req_queue.sv
// Testbench for rf_bank_req_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the bank request queues.
module tb_rf_bank_req_queue;

    logic        clk;
    logic        rst;
    logic        req_en;
    logic        op_a_vld;
    logic        op_b_vld;
    logic [2:0]  rowid_a;
    logic [1:0]  bankid_a;
    logic [2:0]  rowid_b;
    logic [1:0]  bankid_b;
    logic [1:0]  ocid;
    logic        req_ready;
    logic        wb_en;
    logic [1:0]  wb_bank;
    logic [2:0]  wb_row;
    logic [3:0]  bk_rd_vld;
    logic [11:0] bk_rd_row;
    logic [7:0]  bk_rd_ocid;
    logic [3:0]  bk_wr_en;
    logic [2:0]  bk_wr_row;
    logic [3:0]  bk_bz;

    int n_pass  = 0;
    int n_total = 0;

    rf_bank_req_queue dut (
        .clk        (clk),
        .rst        (rst),
        .req_en     (req_en),
        .op_a_vld   (op_a_vld),
        .op_b_vld   (op_b_vld),
        .rowid_a    (rowid_a),
        .bankid_a   (bankid_a),
        .rowid_b    (rowid_b),
        .bankid_b   (bankid_b),
        .ocid       (ocid),
        .req_ready  (req_ready),
        .wb_en      (wb_en),
        .wb_bank    (wb_bank),
        .wb_row     (wb_row),
        .bk_rd_vld  (bk_rd_vld),
        .bk_rd_row  (bk_rd_row),
        .bk_rd_ocid (bk_rd_ocid),
        .bk_wr_en   (bk_wr_en),
        .bk_wr_row  (bk_wr_row),
        .bk_bz      (bk_bz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0] row;
        logic [1:0] oc;
    } ent_t;

    ent_t        mq [4][$];
    logic [3:0]  e_vld;
    logic [11:0] e_row;
    logic [7:0]  e_ocid;
    logic [3:0]  e_wr;
    logic [2:0]  e_wrow;
    logic [3:0]  e_bz;
    logic        e_ready;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) mq[n].delete();
        e_vld = '0; e_row = '0; e_ocid = '0;
        e_wr = '0; e_wrow = '0; e_bz = '0; e_ready = 1'b1;
    endtask

    // Called right after a rising edge. It uses the inputs that were present at
    // that edge, and yields the outputs expected for the following cycle.
    task automatic model_step();
        logic acc;
        ent_t e;
        acc = req_en && e_ready;
        for (int n = 0; n < 4; n++) begin
            if (wb_en && wb_bank == n[1:0]) begin
                e_vld[n] = 1'b0;
                e_bz[n]  = (mq[n].size() != 0);
            end else if (mq[n].size() != 0) begin
                e = mq[n].pop_front();
                e_vld[n]          = 1'b1;
                e_row[n*3 +: 3]   = e.row;
                e_ocid[n*2 +: 2]  = e.oc;
                e_bz[n]           = 1'b0;
            end else begin
                e_vld[n] = 1'b0;
                e_bz[n]  = 1'b0;
            end
        end
        e_wr = wb_en ? (4'b0001 << wb_bank) : 4'b0000;
        if (wb_en) e_wrow = wb_row;
        if (acc && op_a_vld) mq[bankid_a].push_back('{row: rowid_a, oc: ocid});
        if (acc && op_b_vld) mq[bankid_b].push_back('{row: rowid_b, oc: ocid});
        e_ready = 1'b1;
        for (int n = 0; n < 4; n++) if (mq[n].size() > 2) e_ready = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic re, input logic av, input logic [2:0] ra, input logic [1:0] ba,
                         input logic bv, input logic [2:0] rb, input logic [1:0] bb, input logic [1:0] oc,
                         input logic we, input logic [1:0] wbk, input logic [2:0] wr);
        req_en = re; op_a_vld = av; rowid_a = ra; bankid_a = ba;
        op_b_vld = bv; rowid_b = rb; bankid_b = bb; ocid = oc;
        wb_en = we; wb_bank = wbk; wb_row = wr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        n_total++;
        if ({bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_wr_en, bk_wr_row, bk_bz} !== 35'd0)
            $display("FAIL reset_outputs got=%h want=0", {bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_wr_en, bk_wr_row, bk_bz});
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", req_ready); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0000 || req_ready !== 1'b1)
            $display("FAIL reset_release got vld=%b rdy=%b want vld=0000 rdy=1", bk_rd_vld, req_ready);
        else n_pass++;
        $display("reset: done");
    endtask

    task automatic test_single();
        drive(1, 1, 3'd5, 2'd1, 1, 3'd3, 2'd2, 2'd2, 0, 0, 0);
        tick();
        idle();
        n_total++;
        if (bk_rd_vld !== 4'b0000) $display("FAIL single_early got=%b want=0000", bk_rd_vld); else n_pass++;
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0110) $display("FAIL single_vld got=%b want=0110", bk_rd_vld); else n_pass++;
        n_total++;
        if (bk_rd_row[5:3] !== 3'd5 || bk_rd_row[8:6] !== 3'd3)
            $display("FAIL single_rows got b1=%0d b2=%0d want b1=5 b2=3", bk_rd_row[5:3], bk_rd_row[8:6]);
        else n_pass++;
        n_total++;
        if (bk_rd_ocid[3:2] !== 2'd2 || bk_rd_ocid[5:4] !== 2'd2)
            $display("FAIL single_ocid got b1=%0d b2=%0d want 2,2", bk_rd_ocid[3:2], bk_rd_ocid[5:4]);
        else n_pass++;
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0000) $display("FAIL single_idle got=%b want=0000", bk_rd_vld); else n_pass++;
        $display("single: vld=%b", bk_rd_vld);
    endtask

    task automatic test_same_bank();
        drive(1, 1, 3'd1, 2'd0, 1, 3'd6, 2'd0, 2'd1, 0, 0, 0);
        tick();
        idle();
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0001 || bk_rd_row[2:0] !== 3'd1 || bk_rd_ocid[1:0] !== 2'd1)
            $display("FAIL same_bank_first got vld=%b row=%0d oc=%0d want 0001,1,1", bk_rd_vld, bk_rd_row[2:0], bk_rd_ocid[1:0]);
        else n_pass++;
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0001 || bk_rd_row[2:0] !== 3'd6 || bk_rd_ocid[1:0] !== 2'd1)
            $display("FAIL same_bank_second got vld=%b row=%0d oc=%0d want 0001,6,1", bk_rd_vld, bk_rd_row[2:0], bk_rd_ocid[1:0]);
        else n_pass++;
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0000) $display("FAIL same_bank_idle got=%b want=0000", bk_rd_vld); else n_pass++;
        $display("same_bank: done");
    endtask

    task automatic test_write_priority();
        drive(1, 1, 3'd2, 2'd3, 0, 3'd0, 2'd0, 2'd3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 3'd7);
        tick();
        idle();
        n_total++;
        if (bk_wr_en !== 4'b1000 || bk_wr_row !== 3'd7)
            $display("FAIL wprio_write got en=%b row=%0d want 1000,7", bk_wr_en, bk_wr_row);
        else n_pass++;
        n_total++;
        if (bk_bz !== 4'b1000 || bk_rd_vld !== 4'b0000)
            $display("FAIL wprio_busy got bz=%b vld=%b want 1000,0000", bk_bz, bk_rd_vld);
        else n_pass++;
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b1000 || bk_rd_row[11:9] !== 3'd2 || bk_rd_ocid[7:6] !== 2'd3 ||
            bk_wr_en !== 4'b0000 || bk_bz !== 4'b0000)
            $display("FAIL wprio_read got vld=%b row=%0d oc=%0d wr=%b bz=%b want 1000,2,3,0000,0000",
                     bk_rd_vld, bk_rd_row[11:9], bk_rd_ocid[7:6], bk_wr_en, bk_bz);
        else n_pass++;
        tick();
        $display("write_priority: done");
    endtask

    task automatic test_backpressure();
        logic [2:0] rows [4];
        logic       rdys [4];
        rows = '{3'd1, 3'd2, 3'd3, 3'd4};
        rdys = '{1'b0, 1'b1, 1'b1, 1'b1};
        drive(1, 1, 3'd1, 2'd0, 1, 3'd2, 2'd0, 2'd0, 1, 2'd0, 3'd0);
        tick();
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL bp_ready_two got=%b want=1", req_ready); else n_pass++;
        drive(1, 1, 3'd3, 2'd0, 1, 3'd4, 2'd0, 2'd1, 1, 2'd0, 3'd0);
        tick();
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL bp_ready_four got=%b want=0", req_ready); else n_pass++;
        drive(1, 1, 3'd5, 2'd0, 1, 3'd6, 2'd0, 2'd2, 1, 2'd0, 3'd0);
        tick();
        n_total++;
        if (req_ready !== 1'b0 || bk_bz[0] !== 1'b1 || bk_rd_vld !== 4'b0000)
            $display("FAIL bp_ignored got rdy=%b bz0=%b vld=%b want 0,1,0000", req_ready, bk_bz[0], bk_rd_vld);
        else n_pass++;
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (bk_rd_vld !== 4'b0001 || bk_rd_row[2:0] !== rows[i] || req_ready !== rdys[i])
                $display("FAIL bp_drain%0d got vld=%b row=%0d rdy=%b want 0001,%0d,%b",
                         i, bk_rd_vld, bk_rd_row[2:0], req_ready, rows[i], rdys[i]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (bk_rd_vld !== 4'b0000) $display("FAIL bp_no_third got=%b want=0000", bk_rd_vld); else n_pass++;
        $display("backpressure: done");
    endtask

    task automatic test_wrap();
        logic [2:0] row_i;
        logic [1:0] oc_i;
        for (int i = 0; i < 12; i++) begin
            row_i = 3'(i % 8);
            oc_i  = 2'(i % 4);
            if (i < 10) drive(1, 1, row_i, 2'd2, 0, 0, 0, oc_i, 0, 0, 0);
            else        idle();
            tick();
            if (i >= 1 && i <= 10) begin
                row_i = 3'((i - 1) % 8);
                oc_i  = 2'((i - 1) % 4);
                n_total++;
                if (bk_rd_vld !== 4'b0100 || bk_rd_row[8:6] !== row_i || bk_rd_ocid[5:4] !== oc_i)
                    $display("FAIL wrap%0d got vld=%b row=%0d oc=%0d want 0100,%0d,%0d",
                             i - 1, bk_rd_vld, bk_rd_row[8:6], bk_rd_ocid[5:4], row_i, oc_i);
                else n_pass++;
            end
        end
        n_total++;
        if (bk_rd_vld !== 4'b0000) $display("FAIL wrap_idle got=%b want=0000", bk_rd_vld); else n_pass++;
        $display("wrap: done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 9) < 3), 2'($urandom), 3'($urandom));
            tick();
            n_total++;
            if (bk_rd_vld !== e_vld || bk_rd_row !== e_row || bk_rd_ocid !== e_ocid ||
                bk_wr_en !== e_wr || bk_bz !== e_bz || req_ready !== e_ready ||
                (e_wr != 0 && bk_wr_row !== e_wrow)) begin
                errs++;
                $display("FAIL rand%0d got vld=%b row=%h oc=%h wr=%b wrow=%0d bz=%b rdy=%b want %b %h %h %b %0d %b %b",
                         i, bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_wr_en, bk_wr_row, bk_bz, req_ready,
                         e_vld, e_row, e_ocid, e_wr, e_wrow, e_bz, e_ready);
            end else n_pass++;
        end
        idle();
        repeat (8) tick();
        n_total++;
        if (bk_rd_vld !== 4'b0000 || req_ready !== 1'b1)
            $display("FAIL rand_drain got vld=%b rdy=%b want 0000,1", bk_rd_vld, req_ready);
        else n_pass++;
        $display("random: 400 cycles, %0d errors", errs);
    endtask

    task automatic test_async_reset();
        drive(1, 1, 3'd1, 2'd1, 1, 3'd2, 2'd1, 2'd1, 1, 2'd1, 3'd4);
        tick();
        drive(1, 1, 3'd3, 2'd1, 0, 3'd0, 2'd0, 2'd1, 1, 2'd1, 3'd4);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 3'd4);
        tick();
        n_total++;
        if (bk_bz !== 4'b0010 || req_ready !== 1'b0)
            $display("FAIL arst_pre got bz=%b rdy=%b want 0010,0", bk_bz, req_ready);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_wr_en, bk_wr_row, bk_bz} !== 35'd0 || req_ready !== 1'b1)
            $display("FAIL arst_immediate got=%h rdy=%b want 0,1",
                     {bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_wr_en, bk_wr_row, bk_bz}, req_ready);
        else n_pass++;
        idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (bk_rd_vld !== 4'b0000 || req_ready !== 1'b1)
                $display("FAIL arst_stale%0d got vld=%b rdy=%b want 0000,1", i, bk_rd_vld, req_ready);
            else n_pass++;
        end
        $display("async_reset: done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_same_bank();
        test_write_priority();
        test_backpressure();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_bank_req_queue.md
Name: rf_bank_req_queue

Overview:
- Sits between the operand-collector dispatch stage (per-instruction register addresses plus OC id) and the four register-file banks.
- Splits each 2-operand request into per-bank read requests and queues them in one FIFO per bank.
- Each cycle, issues at most one read or one write per bank. CDB write-back takes priority over reads.
- Tags each issued read with its OC id so the matching collector unit captures the bank data.

Parameters:
- NBANK, 4, number of RF banks (fixed at 4; bank id is 2 bits).
- DEPTH, 4, entries per bank FIFO (power of 2, ≥2).
- ROWW, 3, row-address width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- req_en  input  1  request strobe from the dispatch stage.
- op_a_vld  input  1  operand A present.
- op_b_vld  input  1  operand B present.
- rowid_a  input  3  row of operand A.
- bankid_a  input  2  bank of operand A.
- rowid_b  input  3  row of operand B.
- bankid_b  input  2  bank of operand B.
- ocid  input  2  destination collector unit.
- req_ready  output  1  queue can accept a request this cycle.
- wb_en  input  1  CDB register write.
- wb_bank  input  2  write bank.
- wb_row  input  3  write row.
- bk_rd_vld  output  4  per-bank read issued (bit = bank).
- bk_rd_row  output  12  per-bank read row; bank n uses bits [3n+2:3n].
- bk_rd_ocid  output  8  per-bank OC tag; bank n uses bits [2n+1:2n].
- bk_wr_en  output  4  per-bank write issued.
- bk_wr_row  output  3  write row.
- bk_bz  output  4  bank busy: write stole the slot while a read was pending.

Behaviour:
- **Reset.** While rst is high (async assert), all FIFOs are emptied (pointers and counts = 0). Outputs are forced as follows:
  - bk_rd_vld = 0, bk_rd_row = 0, bk_rd_ocid = 0
  - bk_wr_en = 0, bk_wr_row = 0, bk_bz = 0
  - req_ready = 1
- **Reset mid-operation.** Queued requests are discarded; there is no partial issue after release.
- **Accept.** A request is accepted when req_en && req_ready.
  - A request with neither operand valid is accepted and pushes nothing.
  - Operand A pushes {rowid_a, ocid} into FIFO[bankid_a] if op_a_vld.
  - Operand B pushes {rowid_b, ocid} into FIFO[bankid_b] if op_b_vld.
- **Same-bank operands.** If both operands are valid and bankid_a == bankid_b, both entries are pushed in the same cycle, A first then B. They are issued on consecutive free slots.
- **req_ready.** A registered flag, high iff every FIFO count ≤ DEPTH-2. This guarantees room for 2 pushes. It is recomputed each cycle from next-state counts.
- **Per-bank issue, cycle t, combinational from FIFO state.**
  - If wb_en && wb_bank == n: write wins. FIFO[n] is not popped. bk_bz[n] = (count[n] != 0) at t+1.
  - Else if count[n] != 0: pop head. bk_rd_vld[n] = 1, with row/ocid = head, at t+1.
  - Else: bank idle.
- **Write outputs.** bk_wr_en[wb_bank] = 1 and bk_wr_row = wb_row, registered, at t+1.
- **Output validity.** All bank outputs are registered and valid for exactly one cycle. Fields for a bank with rd_vld = 0 hold their last value.
- **Latency.** Request accepted at edge t: entry is visible in cycle t+1, popped in cycle t+1, and bk_rd_vld is high in cycle t+2 (2 cycles, no write conflict). Each write conflict adds one cycle.
- **Simultaneous push and pop** on the same FIFO in one cycle is legal: count changes by pushes − pop.
- **Pointers.** log2(DEPTH)-bit, wrap naturally. Counts are log2(DEPTH)+1 bits.
- **Error case.** A push while the count would exceed DEPTH cannot occur when req_ready is honoured. A request asserted while req_ready = 0 is ignored (no push).
- **Ordering.** Per-bank order is strict FIFO. There is no ordering guarantee across banks.

Test Plan:
- **Single request, no conflict.** After reset, req_en with A = (bank 1, row 5) and B = (bank 2, row 3), ocid 2 → 2 cycles later:
  - bk_rd_vld = 4'b0110
  - bank1 row 5, bank2 row 3, both ocid 2
  - then idle.
- **Same-bank pair.** A = (bank 0, row 1), B = (bank 0, row 6), ocid 1 → bank 0 reads row 1 at t+2, row 6 at t+3, both ocid 1.
- **Write priority.** Queue a read to bank 3 row 2, and assert wb_en with bank 3 row 7 in the pop cycle →
  - next cycle: bk_wr_en = 4'b1000, bk_wr_row = 7, bk_bz[3] = 1, bk_rd_vld[3] = 0
  - the cycle after: read of row 2 issues.
- **Backpressure.** DEPTH = 4. Hold wb_en on bank 0 every cycle while sending 2 requests with both operands to bank 0 →
  - req_ready drops to 0 after count reaches 4
  - a third req_en is ignored
  - after wb_en drops, 4 reads issue in order and req_ready returns to 1 once count ≤ 2.
- **Wrap-around.** Stream 10 single-operand requests to bank 2, rows 0..7,0,1 →
  - reads issue in exact order with correct ocids
  - pointers wrap without loss.
- **Async reset mid-operation.** Assert rst with 3 entries queued in bank 1 → outputs are zero immediately. After release, no stale reads issue and req_ready = 1.
